// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - ALU issue/capture sequencer with flag register and branch evaluation
module alu_issue_ctrl #(
    parameter int         DATA_WIDTH = 32,
    parameter logic [2:0] FLAG_RESET = 3'b000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  op_valid,
    output logic                  op_ready,
    input  logic                  op_is_branch,
    input  logic [3:0]            op_func,
    input  logic                  op_var_shift,
    input  logic                  op_set_flags,
    input  logic [2:0]            br_cond,
    output logic [4:0]            alu_control,
    input  logic [DATA_WIDTH-1:0] alu_out,
    input  logic [2:0]            alu_flags,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  result_we,
    output logic [2:0]            flags_q,
    output logic                  branch_taken,
    output logic                  done,
    output logic                  illegal_op
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ISSUE   = 2'd1;
    localparam logic [1:0] S_CAPTURE = 2'd2;
    localparam logic [1:0] S_BRANCH  = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [3:0]            func_q, func_d;
    logic                  var_shift_q, var_shift_d;
    logic                  set_flags_q, set_flags_d;
    logic [2:0]            cond_q, cond_d;
    logic                  illegal_q, illegal_d;
    logic                  op_ready_q, op_ready_d;
    logic [4:0]            alu_control_q, alu_control_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic                  result_we_q, result_we_d;
    logic [2:0]            flags_d;
    logic                  branch_taken_q, branch_taken_d;
    logic                  done_q, done_d;
    logic                  illegal_op_q, illegal_op_d;
    logic                  cond_met;
    logic                  func_legal;

    assign op_ready     = op_ready_q;
    assign alu_control  = alu_control_q;
    assign result       = result_q;
    assign result_we    = result_we_q;
    assign branch_taken = branch_taken_q;
    assign done         = done_q;
    assign illegal_op   = illegal_op_q;

    assign func_legal = (func_q <= 4'd8);

    // flags_q[0]=zero, [1]=sign, [2]=carry
    always_comb begin
        cond_met = 1'b0;
        case (cond_q)
            3'd0: cond_met = 1'b1;
            3'd1: cond_met = flags_q[0];
            3'd2: cond_met = ~flags_q[0];
            3'd3: cond_met = ~flags_q[1];
            3'd4: cond_met = flags_q[1];
            3'd5: cond_met = flags_q[2];
            3'd6: cond_met = ~flags_q[2];
            default: cond_met = 1'b0;
        endcase
    end

    always_comb begin
        state_d        = state_q;
        func_d         = func_q;
        var_shift_d    = var_shift_q;
        set_flags_d    = set_flags_q;
        cond_d         = cond_q;
        illegal_d      = illegal_q;
        op_ready_d     = op_ready_q;
        alu_control_d  = alu_control_q;
        result_d       = result_q;
        result_we_d    = 1'b0;
        flags_d        = flags_q;
        branch_taken_d = branch_taken_q;
        done_d         = 1'b0;
        illegal_op_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (op_valid) begin
                    func_d      = op_func;
                    var_shift_d = op_var_shift;
                    set_flags_d = op_set_flags;
                    cond_d      = br_cond;
                    op_ready_d  = 1'b0;
                    state_d     = op_is_branch ? S_BRANCH : S_ISSUE;
                end
            end
            S_ISSUE: begin
                alu_control_d = func_legal ? {var_shift_q && (func_q >= 4'd6), func_q} : 5'b0;
                illegal_d     = ~func_legal;
                state_d       = S_CAPTURE;
            end
            S_CAPTURE: begin
                result_d    = alu_out;
                result_we_d = ~illegal_q;
                // Carry is only meaningful from add; every other op leaves it alone.
                if (set_flags_q && !illegal_q) begin
                    flags_d[1:0] = alu_flags[1:0];
                    if (func_q == 4'd0) begin
                        flags_d[2] = alu_flags[2];
                    end
                end
                done_d       = 1'b1;
                illegal_op_d = illegal_q;
                op_ready_d   = 1'b1;
                state_d      = S_IDLE;
            end
            default: begin
                branch_taken_d = cond_met;
                done_d         = 1'b1;
                op_ready_d     = 1'b1;
                state_d        = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            func_q         <= 4'd0;
            var_shift_q    <= 1'b0;
            set_flags_q    <= 1'b0;
            cond_q         <= 3'd0;
            illegal_q      <= 1'b0;
            op_ready_q     <= 1'b1;
            alu_control_q  <= 5'b0;
            result_q       <= '0;
            result_we_q    <= 1'b0;
            flags_q        <= FLAG_RESET;
            branch_taken_q <= 1'b0;
            done_q         <= 1'b0;
            illegal_op_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            func_q         <= func_d;
            var_shift_q    <= var_shift_d;
            set_flags_q    <= set_flags_d;
            cond_q         <= cond_d;
            illegal_q      <= illegal_d;
            op_ready_q     <= op_ready_d;
            alu_control_q  <= alu_control_d;
            result_q       <= result_d;
            result_we_q    <= result_we_d;
            flags_q        <= flags_d;
            branch_taken_q <= branch_taken_d;
            done_q         <= done_d;
            illegal_op_q   <= illegal_op_d;
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - directed scoreboard bench for alu_issue_ctrl
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        op_valid;
    logic        op_ready;
    logic        op_is_branch;
    logic [3:0]  op_func;
    logic        op_var_shift;
    logic        op_set_flags;
    logic [2:0]  br_cond;
    logic [4:0]  alu_control;
    logic [31:0] alu_out;
    logic [2:0]  alu_flags;
    logic [31:0] result;
    logic        result_we;
    logic [2:0]  flags_q;
    logic        branch_taken;
    logic        done;
    logic        illegal_op;

    always #5 clk = ~clk;

    alu_issue_ctrl #(.DATA_WIDTH(32), .FLAG_RESET(3'b000)) dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready),
        .op_is_branch(op_is_branch), .op_func(op_func), .op_var_shift(op_var_shift),
        .op_set_flags(op_set_flags), .br_cond(br_cond), .alu_control(alu_control),
        .alu_out(alu_out), .alu_flags(alu_flags), .result(result), .result_we(result_we),
        .flags_q(flags_q), .branch_taken(branch_taken), .done(done), .illegal_op(illegal_op)
    );

    typedef struct {
        logic [31:0] res;
        logic        we;
        logic        ill;
        logic [2:0]  fl;
        logic [4:0]  ctrl;
        logic        is_br;
        logic        bt;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [2:0]  m_flags = 3'b000;
    logic [31:0] m_result = 32'h0;
    logic [4:0]  m_ctrl = 5'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic br_model(input logic [2:0] c, input logic [2:0] f);
        logic z, s, cy;
        z = f[0]; s = f[1]; cy = f[2];
        case (c)
            3'd0: return 1'b1;
            3'd1: return z;
            3'd2: return !z;
            3'd3: return !s;
            3'd4: return s;
            3'd5: return cy;
            3'd6: return !cy;
            default: return 1'b0;
        endcase
    endfunction

    // Entered and left at a negedge.
    task automatic run_op(input string tag, input logic is_br, input logic [3:0] func,
                          input logic vs, input logic sf, input logic [2:0] cond,
                          input logic [31:0] aout, input logic [2:0] aflags);
        exp_t e;
        int   lat;
        chk({tag, ".ready_pre"}, {31'b0, op_ready}, 32'd1);
        op_valid = 1'b1; op_is_branch = is_br; op_func = func; op_var_shift = vs;
        op_set_flags = sf; br_cond = cond; alu_out = aout; alu_flags = aflags;
        e.is_br = is_br;
        if (is_br) begin
            e.bt = br_model(cond, m_flags);
            e.we = 1'b0; e.ill = 1'b0; e.lat = 2;
        end else begin
            e.bt = 1'b0;
            e.ill = (func > 4'd8);
            e.we = !e.ill;
            m_ctrl = e.ill ? 5'b0 : {vs && (func == 4'd6 || func == 4'd7 || func == 4'd8), func};
            m_result = aout;
            if (sf && !e.ill) begin
                m_flags[0] = aflags[0];
                m_flags[1] = aflags[1];
                if (func == 4'd0) m_flags[2] = aflags[2];
            end
            e.lat = 3;
        end
        e.res = m_result; e.fl = m_flags; e.ctrl = m_ctrl;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        op_valid = 1'b0;
        chk({tag, ".busy_ready"}, {31'b0, op_ready}, 32'd0);
        lat = 1;
        while (!done && lat < 10) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        if (!done) begin
            chk({tag, ".done_timeout"}, {31'b0, done}, 32'd1);
            void'(sb.pop_front());
        end else begin
            e = sb.pop_front();
            chk({tag, ".latency"}, lat, e.lat);
            chk({tag, ".result"}, result, e.res);
            chk({tag, ".result_we"}, {31'b0, result_we}, {31'b0, e.we});
            chk({tag, ".illegal_op"}, {31'b0, illegal_op}, {31'b0, e.ill});
            chk({tag, ".flags_q"}, {29'b0, flags_q}, {29'b0, e.fl});
            chk({tag, ".alu_control"}, {27'b0, alu_control}, {27'b0, e.ctrl});
            chk({tag, ".ready_done"}, {31'b0, op_ready}, 32'd1);
            if (e.is_br) chk({tag, ".branch_taken"}, {31'b0, branch_taken}, {31'b0, e.bt});
        end
        @(posedge clk);
        @(negedge clk);
        chk({tag, ".done_pulse"}, {31'b0, done}, 32'd0);
    endtask

    int done_cyc[4];
    int ndone, acc, cyc, extra;

    initial begin
        rst = 1'b1; op_valid = 1'b0; op_is_branch = 1'b0; op_func = 4'd0;
        op_var_shift = 1'b0; op_set_flags = 1'b0; br_cond = 3'd0;
        alu_out = 32'h0; alu_flags = 3'b000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst.op_ready", {31'b0, op_ready}, 32'd1);
        chk("rst.alu_control", {27'b0, alu_control}, 32'd0);
        chk("rst.result", result, 32'd0);
        chk("rst.result_we", {31'b0, result_we}, 32'd0);
        chk("rst.flags_q", {29'b0, flags_q}, 32'd0);
        chk("rst.branch_taken", {31'b0, branch_taken}, 32'd0);
        chk("rst.done", {31'b0, done}, 32'd0);
        chk("rst.illegal_op", {31'b0, illegal_op}, 32'd0);

        run_op("and_vs",   1'b0, 4'd2, 1'b1, 1'b0, 3'd0, 32'hDEAD_BEEF, 3'b111);
        run_op("srl_vs",   1'b0, 4'd7, 1'b1, 1'b1, 3'd0, 32'h1234_5678, 3'b110);
        run_op("add_flag", 1'b0, 4'd0, 1'b0, 1'b1, 3'd0, 32'h0000_0000, 3'b101);
        run_op("sll_imm",  1'b0, 4'd6, 1'b0, 1'b0, 3'd0, 32'hA5A5_0000, 3'b000);
        run_op("add_clr",  1'b0, 4'd0, 1'b0, 1'b1, 3'd0, 32'h0000_0042, 3'b000);
        run_op("sub_flag", 1'b0, 4'd1, 1'b0, 1'b1, 3'd0, 32'hFFFF_FFF0, 3'b111);
        for (int c = 0; c < 8; c++) begin
            run_op($sformatf("br%0d", c), 1'b1, 4'd0, 1'b0, 1'b0, 3'(c), 32'h5555_5555, 3'b000);
        end
        run_op("illegal", 1'b0, 4'hB, 1'b1, 1'b1, 3'd0, 32'h0000_FFFF, 3'b111);
        run_op("br_after_ill", 1'b1, 4'd0, 1'b0, 1'b0, 3'd1, 32'h0, 3'b000);

        // Continuous request: three adds, valid held until the third accept.
        op_valid = 1'b1; op_is_branch = 1'b0; op_func = 4'd0; op_var_shift = 1'b0;
        op_set_flags = 1'b0; alu_out = 32'h0BAD_F00D; alu_flags = 3'b000;
        acc = 0; ndone = 0; cyc = 0;
        while (cyc < 40 && (acc < 3 || ndone < 3)) begin
            if (op_valid && op_ready) acc++;
            @(posedge clk);
            @(negedge clk);
            cyc++;
            if (acc == 3) op_valid = 1'b0;
            if (done) begin
                if (ndone < 4) done_cyc[ndone] = cyc;
                ndone++;
                chk("b2b.result", result, 32'h0BAD_F00D);
                chk("b2b.result_we", {31'b0, result_we}, 32'd1);
            end
        end
        extra = 0;
        repeat (6) begin
            @(posedge clk);
            @(negedge clk);
            if (done) extra++;
        end
        chk("b2b.ndone", ndone, 3);
        chk("b2b.extra_done", extra, 0);
        if (ndone >= 3) begin
            chk("b2b.space01", done_cyc[1] - done_cyc[0], 3);
            chk("b2b.space12", done_cyc[2] - done_cyc[1], 3);
        end

        // Reset asserted during CAPTURE of a flag-setting add.
        chk("rmo.flags_before", {29'b0, flags_q}, {29'b0, m_flags});
        op_valid = 1'b1; op_func = 4'd0; op_set_flags = 1'b1;
        alu_out = 32'h7777_7777; alu_flags = 3'b111;
        @(posedge clk);
        @(negedge clk);
        op_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rmo.done", {31'b0, done}, 32'd0);
        chk("rmo.result_we", {31'b0, result_we}, 32'd0);
        chk("rmo.flags_q", {29'b0, flags_q}, 32'd0);
        chk("rmo.op_ready", {31'b0, op_ready}, 32'd1);
        chk("rmo.result", result, 32'd0);
        chk("rmo.alu_control", {27'b0, alu_control}, 32'd0);
        extra = 0;
        repeat (4) begin
            @(posedge clk);
            @(negedge clk);
            if (done || result_we) extra++;
        end
        chk("rmo.no_pulse", extra, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
